piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in/serial-out transmitter. Accepts a W-bit word over a valid/ready load handshake and emits it as W/SHIFT_W beats of SHIFT_W bits each, one beat per cycle that shift_en is high.
- Mirror of the shift-in deserializer: paired with the same SHIFT_W and SHIFT_DIR, the far end reconstructs the word bit-exactly.
- Sits between a word-oriented producer and a serial line or bit-tick domain.

Parameters:
- W, 8: parallel word width; W % SHIFT_W must be 0.
- SHIFT_W, 1: bits per serial beat.
- SHIFT_DIR, SHIFT_DIR_LEFT: LEFT sends the MSB chunk first; RIGHT sends the LSB chunk first.
- IDLE_VAL, 0: value driven on sout while idle (SHIFT_W bits).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  producer has a word.
- load_data  in  W  word to send; sampled only on a handshake.
- load_ready  out  1  serializer can take a word this cycle.
- shift_en  in  1  consume the current beat this cycle (bit tick).
- sout  out  SHIFT_W  current beat.
- sout_valid  out  1  sout carries word data.
- first  out  1  current beat is beat 0 of the word.
- last  out  1  current beat is beat BEATS-1.
- busy  out  1  word in flight (equal to sout_valid).

Behaviour:
- Derived values: BEATS = W/SHIFT_W. Counter width CW = CLOG2(BEATS+1).
- State: state ∈ {IDLE, SHIFT}, shift register sr[W-1:0], beat counter cnt[CW-1:0].
- Reset (rst_n=0, async): state=IDLE, sr=0, cnt=0. Outputs: load_ready=1, sout=IDLE_VAL, sout_valid=busy=first=last=0. Deassertion takes effect at the next clk edge. A word in flight is discarded, with no partial completion.
- load_ready (combinational) = (state==IDLE) | (state==SHIFT & shift_en & last).
- Handshake: accept = load_valid & load_ready. On accept: sr<=load_data, cnt<=0, state<=SHIFT. Beat 0 appears on sout in the following cycle (1-cycle latency from accept).
- sout (combinational from sr):
  - LEFT: sr[W-1 -: SHIFT_W].
  - RIGHT: sr[SHIFT_W-1:0].
  - IDLE: IDLE_VAL.
- In SHIFT with shift_en=1 and not last: shift sr by SHIFT_W toward the exit end, zero-fill the vacated bits, cnt<=cnt+1.
- In SHIFT with shift_en=0: sr, cnt and all outputs hold. A stall may be any length.
- Last beat consumed (shift_en & last):
  - if load_valid: the new word loads in the same edge, so there is no idle bubble between words;
  - else: state<=IDLE, cnt<=0.
- first = (state==SHIFT) & (cnt==0). last = (state==SHIFT) & (cnt==BEATS-1). If BEATS==1, both are high on the same beat.
- load_valid while busy and not consuming the last beat: load_ready=0, nothing is accepted, and load_data is ignored.
- shift_en while IDLE: no effect.
- load_data may change freely when there is no handshake.
- cnt never exceeds BEATS-1; there is no wrap-around other than reload to 0.

Decomposition:
- Shared header, alongside the existing DIR/SHIFT_DIR defines: reuse SHIFT_DIR_LEFT/RIGHT and CLOG2. Add localparam-style macros only if the matching deserializer needs them too.
- One natural sub-module: ff_arn, a W-parameterised register with asynchronous active-low reset and RESET_VAL. It is the rst_n counterpart of the existing async-reset flop and is instantiated for state, sr and cnt.
- Next-state and output logic stay in piso_serializer.

Test Plan:
- W=8, SHIFT_W=1, LEFT, shift_en tied 1; load 0xA5 → after 1 cycle sout = 1,0,1,0,0,1,0,1 over 8 cycles; first on beat 0, last on beat 7; then IDLE with sout=0 and load_ready=1.
- Back-to-back: load_valid held with 0xA5 then 0x3C, shift_en=1 → 16 contiguous beats 10100101 00111100; load_ready pulses only on the last beat of 0xA5; sout_valid never drops.
- Stalls: 0xA5 with shift_en pattern 1,0,0,1,… → sout holds each value for stalled cycles; exactly 8 enabled cycles complete the word; cnt never skips.
- W=8, SHIFT_W=2, RIGHT; load 0xB4 → beats 2'b00, 2'b01, 2'b11, 2'b10; last on beat 3.
- Busy rejection: offer 0xFF at beat 3 of 0xA5 → load_ready=0, 0xFF not taken, and the 0xA5 beats are unchanged. Then assert rst_n=0 at beat 4 → outputs go to reset values immediately (async); after release, a fresh 0x3C serializes correctly from beat 0.
- BEATS=1 (W=4, SHIFT_W=4): load 0x9 → one beat 4'h9 with first=last=1. With load_valid held, every shift_en cycle accepts a new word.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: shared shift-direction and state types plus a constant clog2 helper.
package piso_serializer_pkg;

    typedef enum logic {SHIFT_DIR_LEFT, SHIFT_DIR_RIGHT} shift_dir_e;
    typedef enum logic {IDLE, SHIFT} state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; (1 << i) < n; i++) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/piso_serializer_ff_arn.sv
// ff_arn: W-bit register with asynchronous active-low reset to RESET_VAL.
module ff_arn #(
    parameter int W = 1,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_o <= RESET_VAL;
        else q_o <= d_i;
    end

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready loaded word shifted out SHIFT_W bits per shift_en beat.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int W = 8,
    parameter int SHIFT_W = 1,
    parameter shift_dir_e SHIFT_DIR = SHIFT_DIR_LEFT,
    parameter logic [SHIFT_W-1:0] IDLE_VAL = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_valid,
    input  logic [W-1:0]       load_data,
    output logic               load_ready,
    input  logic               shift_en,
    output logic [SHIFT_W-1:0] sout,
    output logic               sout_valid,
    output logic               first,
    output logic               last,
    output logic               busy
);

    localparam int BEATS = W / SHIFT_W;
    localparam int CW = clog2(BEATS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    state_e        state_d, state_q;
    logic          st_q;
    logic [W-1:0]  sr_d, sr_q, sr_shift;
    logic [CW-1:0] cnt_d, cnt_q;
    logic          in_shift, accept;

    ff_arn #(.W(1), .RESET_VAL(1'b0)) u_state (.clk(clk), .rst_n(rst_n), .d_i(state_d), .q_o(st_q));
    ff_arn #(.W(W), .RESET_VAL('0)) u_sr (.clk(clk), .rst_n(rst_n), .d_i(sr_d), .q_o(sr_q));
    ff_arn #(.W(CW), .RESET_VAL('0)) u_cnt (.clk(clk), .rst_n(rst_n), .d_i(cnt_d), .q_o(cnt_q));

    assign state_q = state_e'(st_q);

    always_comb begin
        in_shift   = state_q == SHIFT;
        first      = in_shift && cnt_q == '0;
        last       = in_shift && cnt_q == LAST_CNT;
        sout_valid = in_shift;
        busy       = in_shift;
        // A word can be taken while the final beat of the previous one drains.
        load_ready = !in_shift || (shift_en && last);
        accept     = load_valid && load_ready;
        sr_shift   = SHIFT_DIR == SHIFT_DIR_LEFT ? sr_q << SHIFT_W : sr_q >> SHIFT_W;
        sout       = !in_shift ? IDLE_VAL
                   : SHIFT_DIR == SHIFT_DIR_LEFT ? sr_q[W-1 -: SHIFT_W] : sr_q[SHIFT_W-1:0];
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        if (accept) begin
            state_d = SHIFT;
            sr_d    = load_data;
            cnt_d   = '0;
        end else if (in_shift && shift_en) begin
            state_d = last ? IDLE : SHIFT;
            sr_d    = last ? sr_q : sr_shift;
            cnt_d   = last ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: three configurations checked against a per-word expected-beat list.
module tb_piso_serializer;
    import piso_serializer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lv [3];
    logic [7:0] ld [3];
    logic       se [3];
    logic       rd [3];
    logic       sv [3];
    logic       fi [3];
    logic       la [3];
    logic       bz [3];
    logic [0:0] sout_a;
    logic [1:0] sout_b;
    logic [3:0] sout_c;

    int dw [3] = '{8, 8, 4};
    int ds [3] = '{1, 2, 4};
    bit dl [3] = '{1'b1, 1'b0, 1'b1};

    logic [3:0] eb [3][8];
    int pos [3];
    int rem [3];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    piso_serializer #(.W(8), .SHIFT_W(1), .SHIFT_DIR(SHIFT_DIR_LEFT)) u_a (
        .clk(clk), .rst_n(rst_n), .load_valid(lv[0]), .load_data(ld[0]), .load_ready(rd[0]),
        .shift_en(se[0]), .sout(sout_a), .sout_valid(sv[0]), .first(fi[0]), .last(la[0]), .busy(bz[0]));
    piso_serializer #(.W(8), .SHIFT_W(2), .SHIFT_DIR(SHIFT_DIR_RIGHT)) u_b (
        .clk(clk), .rst_n(rst_n), .load_valid(lv[1]), .load_data(ld[1]), .load_ready(rd[1]),
        .shift_en(se[1]), .sout(sout_b), .sout_valid(sv[1]), .first(fi[1]), .last(la[1]), .busy(bz[1]));
    piso_serializer #(.W(4), .SHIFT_W(4), .SHIFT_DIR(SHIFT_DIR_LEFT)) u_c (
        .clk(clk), .rst_n(rst_n), .load_valid(lv[2]), .load_data(ld[2][3:0]), .load_ready(rd[2]),
        .shift_en(se[2]), .sout(sout_c), .sout_valid(sv[2]), .first(fi[2]), .last(la[2]), .busy(bz[2]));

    function automatic logic [7:0] obs(int d);
        return d == 0 ? {7'b0, sout_a} : d == 1 ? {6'b0, sout_b} : {4'b0, sout_c};
    endfunction

    task automatic chk(string tag, int d, logic [7:0] got, logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, got, exp);
        end
    endtask

    task automatic set(int d, logic v, logic [7:0] data, logic en);
        lv[d] = v;
        ld[d] = data;
        se[d] = en;
    endtask

    task automatic chk_idle_all(string tag);
        for (int d = 0; d < 3; d++) begin
            chk({tag, "_sout"}, d, obs(d), 8'h00);
            chk({tag, "_valid"}, d, 8'(sv[d]), 8'h00);
            chk({tag, "_busy"}, d, 8'(bz[d]), 8'h00);
            chk({tag, "_first"}, d, 8'(fi[d]), 8'h00);
            chk({tag, "_last"}, d, 8'(la[d]), 8'h00);
            chk({tag, "_ready"}, d, 8'(rd[d]), 8'h01);
            rem[d] = 0;
            pos[d] = 0;
        end
    endtask

    // Checks every DUT mid-cycle, then advances the expected-beat lists across the edge.
    task automatic cycle();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            bit act, er;
            int b, word, sh;
            act = rem[d] > 0;
            b = dw[d] / ds[d];
            er = !act || (se[d] && rem[d] == 1);
            chk("sout", d, obs(d), act ? 8'(eb[d][pos[d]]) : 8'h00);
            chk("sout_valid", d, 8'(sv[d]), 8'(act));
            chk("busy", d, 8'(bz[d]), 8'(act));
            chk("first", d, 8'(fi[d]), 8'(act && pos[d] == 0));
            chk("last", d, 8'(la[d]), 8'(act && rem[d] == 1));
            chk("load_ready", d, 8'(rd[d]), 8'(er));
            if (lv[d] && er) begin
                word = int'(ld[d]) & ((1 << dw[d]) - 1);
                for (int k = 0; k < b; k++) begin
                    sh = dl[d] ? dw[d] - (k + 1) * ds[d] : k * ds[d];
                    eb[d][k] = 4'((word >> sh) & ((1 << ds[d]) - 1));
                end
                pos[d] = 0;
                rem[d] = b;
            end else if (act && se[d]) begin
                pos[d]++;
                rem[d]--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) set(d, 1'b0, 8'h00, 1'b0);
        #12;
        chk_idle_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set(0, 1'b1, 8'hA5, 1'b1);
        cycle();
        set(0, 1'b0, 8'h00, 1'b1);
        repeat (10) cycle();
        set(0, 1'b1, 8'hA5, 1'b1);
        cycle();
        ld[0] = 8'h3C;
        repeat (8) cycle();
        lv[0] = 1'b0;
        repeat (10) cycle();
        set(0, 1'b1, 8'hA5, 1'b1);
        cycle();
        lv[0] = 1'b0;
        for (int i = 0; i < 24; i++) begin
            se[0] = (i % 3 == 0) || ($urandom_range(0, 3) == 0);
            cycle();
        end
        se[0] = 1'b1;
        repeat (10) cycle();
        set(0, 1'b1, 8'hA5, 1'b1);
        cycle();
        lv[0] = 1'b0;
        repeat (3) cycle();
        set(0, 1'b1, 8'hFF, 1'b1);
        cycle();
        lv[0] = 1'b0;
        cycle();
        rst_n = 1'b0;
        #1;
        chk_idle_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set(0, 1'b1, 8'h3C, 1'b1);
        cycle();
        lv[0] = 1'b0;
        repeat (10) cycle();
        set(1, 1'b1, 8'hB4, 1'b1);
        cycle();
        lv[1] = 1'b0;
        repeat (6) cycle();
        set(2, 1'b1, 8'h09, 1'b1);
        cycle();
        lv[2] = 1'b0;
        repeat (3) cycle();
        lv[2] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            ld[2] = 8'($urandom);
            se[2] = $urandom_range(0, 1) == 1;
            cycle();
        end
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 3; d++) set(d, $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 3) != 0);
            cycle();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
